// File: rtl/tl_pkg.sv
// tl_pkg: state codes and per-state decode helpers
// for the two-road traffic light controller.
package tl_pkg;

  typedef enum logic [2:0] {
    G1  = 3'd0,
    Y1  = 3'd1,
    AR1 = 3'd2,
    G2  = 3'd3,
    Y2  = 3'd4,
    AR2 = 3'd5
  } tl_state_e;

  function automatic logic [6:0] dur_of(
    input tl_state_e  s,
    input logic [6:0] g,
    input logic [6:0] y,
    input logic [6:0] a
  );
    case (s)
      G1, G2:  return g;
      Y1, Y2:  return y;
      default: return a;
    endcase
  endfunction

  // {x1,v1,d1,x2,v2,d2}; unknown codes fall back to all red
  function automatic logic [5:0] lights_of(input tl_state_e s);
    case (s)
      G1:      return 6'b100_001;
      Y1:      return 6'b010_001;
      G2:      return 6'b001_100;
      Y2:      return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  function automatic tl_state_e next_of(input tl_state_e s);
    case (s)
      G1:      return Y1;
      Y1:      return AR1;
      AR1:     return G2;
      G2:      return Y2;
      Y2:      return AR2;
      default: return G1;
    endcase
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// tl_tick_gen: divides clk down to a one-cycle
// pulse every TICK_DIV cycles.
module tl_tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LP_LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LP_LAST);
  assign o_tick = w_last;

  // Free-running prescaler, wraps on the tick cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road light sequencer with BCD countdown.
// Optional night flashing-yellow mode: define TL_NIGHT_FLASH_EN.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GREEN_S  = 25,
  parameter int unsigned YELLOW_S = 3,
  parameter int unsigned ALLRED_S = 2
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       hold,
`ifdef TL_NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic       x1,
  output logic       v1,
  output logic       d1,
  output logic       x2,
  output logic       v2,
  output logic       d2,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] phase,
  output logic       sec_tick
);

  if (TICK_DIV < 2 ||
      GREEN_S  < 1 || GREEN_S  > 99 ||
      YELLOW_S < 1 || YELLOW_S > 99 ||
      ALLRED_S < 1 || ALLRED_S > 99) begin : g_param_err
    $error("traffic_light_ctrl: parameter out of range");
  end

  localparam logic [6:0] LP_G = 7'(GREEN_S);
  localparam logic [6:0] LP_Y = 7'(YELLOW_S);
  localparam logic [6:0] LP_A = 7'(ALLRED_S);

  tl_state_e  r_state;
  tl_state_e  w_state_nxt;
  logic [6:0] r_cnt;
  logic [6:0] w_cnt_nxt;
  logic [5:0] r_lights;
  logic [5:0] w_lights_nxt;
  logic       w_tick;
  logic       w_flashing;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

`ifdef TL_NIGHT_FLASH_EN
  logic r_night;
  logic r_flash;
  logic w_flash_nxt;
  assign w_flashing = r_night;
`else
  assign w_flashing = 1'b0;
`endif

  tl_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk (clk),
    .i_rst (rs),
    .o_tick(w_tick)
  );

  // Next state, countdown and lights decoded from next state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state > AR2) begin
      w_state_nxt = AR1;
      w_cnt_nxt   = LP_A;
    end else if (w_tick && !hold) begin
      if (r_cnt == 7'd1) begin
        w_state_nxt = next_of(r_state);
        w_cnt_nxt   = dur_of(w_state_nxt, LP_G, LP_Y, LP_A);
      end else begin
        w_cnt_nxt = r_cnt - 7'd1;
      end
    end
    w_lights_nxt = lights_of(w_state_nxt);
`ifdef TL_NIGHT_FLASH_EN
    w_flash_nxt = r_flash;
    if (night) begin
      if (!r_night) begin
        w_flash_nxt = 1'b1;
      end else if (w_tick) begin
        w_flash_nxt = ~r_flash;
      end
      w_state_nxt  = AR2;
      w_cnt_nxt    = 7'd0;
      w_lights_nxt = {1'b0, w_flash_nxt, 2'b00,
                      w_flash_nxt, 1'b0};
    end else if (r_night) begin
      w_state_nxt  = G1;
      w_cnt_nxt    = LP_G;
      w_lights_nxt = lights_of(G1);
    end
`endif
  end

  // State, countdown and light registers.
  always_ff @(posedge clk) begin
    if (rs) begin
      r_state  <= G1;
      r_cnt    <= LP_G;
      r_lights <= lights_of(G1);
`ifdef TL_NIGHT_FLASH_EN
      r_night  <= 1'b0;
      r_flash  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lights <= w_lights_nxt;
`ifdef TL_NIGHT_FLASH_EN
      r_night  <= night;
      r_flash  <= w_flash_nxt;
`endif
    end
  end

  // BCD split by comparing against each multiple of ten.
  always_comb begin
    w_tens = 4'd0;
    w_ones = r_cnt[3:0];
    for (int i = 1; i < 10; i++) begin
      if (r_cnt >= 7'(i * 10)) begin
        w_tens = 4'(i);
        w_ones = 4'(r_cnt - 7'(i * 10));
      end
    end
  end

  assign {x1, v1, d1, x2, v2, d2} = r_lights;
  assign sec_tens = w_tens;
  assign sec_ones = w_ones;
  assign phase    = r_state;
  assign sec_tick = w_tick;

  // Flag any cycle that shows conflicting lights.
  always @(posedge clk) begin
    if (!rs && !w_flashing) begin
      assert (!(x1 && x2))
        else $error("both roads green");
      assert ($onehot({x1, v1, d1}) && $onehot({x2, v2, d2}))
        else $error("road lights not one-hot");
    end
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised two-road traffic-light controller.
- Sequences green, yellow and all-red phases for road 1 and road 2 from one 1 Hz tick derived from clk.
- Exports the remaining seconds of the current phase as two BCD digits, which the LCD character builder renders as ASCII.
- Generalises the fixed-timing controller: phase durations, clock rate and hold control are configurable.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick (sims use a small value); must be ≥ 2.
- GREEN_S, 25: green duration in seconds; range 1..99.
- YELLOW_S, 3: yellow duration in seconds; range 1..99.
- ALLRED_S, 2: all-red clearance in seconds; range 1..99.
- Out-of-range values: elaboration error.

Ports:
- clk  in  1  system clock; single clock domain.
- rs  in  1  synchronous reset, active-high.
- hold  in  1  freeze phase and countdown while high.
- x1  out  1  road 1 green.
- v1  out  1  road 1 yellow.
- d1  out  1  road 1 red.
- x2  out  1  road 2 green.
- v2  out  1  road 2 yellow.
- d2  out  1  road 2 red.
- sec_tens  out  4  BCD tens digit of seconds remaining.
- sec_ones  out  4  BCD ones digit of seconds remaining.
- phase  out  3  current state code.
- sec_tick  out  1  one-cycle pulse per second.

Behaviour:
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - sec_tick=1 for exactly the cycle in which it equals TICK_DIV-1; it wraps to 0 on that cycle.
  - Prescaler keeps running when hold=1.
- FSM states, with codes and the lights driven in each:
  - G1=0: x1 and d2 on.
  - Y1=1: v1 and d2 on.
  - AR1=2: d1 and d2 on.
  - G2=3: d1 and x2 on.
  - Y2=4: d1 and v2 on.
  - AR2=5: d1 and d2 on.
- State order is G1→Y1→AR1→G2→Y2→AR2→G1.
- Countdown register cnt (7 bits):
  - On sec_tick with hold=0: if cnt==1, advance state and load the next state's duration; otherwise cnt←cnt-1.
  - Durations: G*→GREEN_S, Y*→YELLOW_S, AR*→ALLRED_S.
- sec_tens/sec_ones are combinational BCD of cnt, from a divide-by-10 compare chain; cnt ≤ 99 is guaranteed.
- Lights are registered, decoded from the next-state value, so they change in the same cycle as the state.
- Exactly one light per road is on in every cycle. Green on both roads is never allowed; asserted in simulation.
- Reset (rs=1 at a clk edge):
  - state=G1, cnt=GREEN_S, prescaler=0, sec_tick=0.
  - Lights: x1=1, d2=1, all other lights 0.
  - Reset mid-phase discards all progress. It takes priority over hold and over tick.
- hold=1: sec_tick pulses are ignored, so state and cnt stay frozen. After hold falls, the first tick resumes decrementing.
- Duration 1: the phase lasts exactly one tick; the transition happens on the first tick after entry.
- Illegal state code (6, 7): next cycle goes to AR1 with cnt=ALLRED_S, a safe all-red.

Optional Feature:
- Macro TL_NIGHT_FLASH_EN.
- Defined:
  - Adds input night (1 bit).
  - While night=1, both roads show flashing yellow: v1=v2 toggle on each sec_tick and start at 1. All other lights are 0, the FSM is held in AR2 and cnt=0, so the display reads 00.
  - When night falls: state=G1, cnt=GREEN_S, lights as after reset.
- Undefined: no night port, no flashing logic.

Decomposition:
- Package tl_pkg holds:
  - the state encoding constants G1..AR2;
  - a function dur_of(state) returning the duration parameter for each state;
  - a light-decode function mapping state to {x1,v1,d1,x2,v2,d2}.
- One sub-module, tl_tick_gen: the prescaler producing sec_tick, parametrised by TICK_DIV.
- BCD split and FSM stay in traffic_light_ctrl.

Test Plan:
All scenarios use TICK_DIV=4, GREEN_S=5, YELLOW_S=2, ALLRED_S=1.
1. Release rs, run 64 clk cycles (one full 16 s cycle) → phase sequence 0,1,2,3,4,5,0. Phases last 20, 8, 4, 20, 8, 4 clk. sec_tens/sec_ones count 05,04,03,02,01 during G1.
2. Assert hold at cnt=3 in G2 for 12 clk → phase stays 3 and digits stay 03 across 3 ticks. After release, 02 appears at the next tick.
3. Assert rs for 1 clk during Y1 → the next cycle has phase=0, digits 05, and lights x1=1, d2=1, all others 0.
4. Rerun with GREEN_S=99 → display reads 99 then 98. Rerun with YELLOW_S=1 → Y1 lasts exactly 4 clk.
5. Monitor all cycles of scenarios 1–4 → never x1&x2; each road always has exactly one light on.
6. With TL_NIGHT_FLASH_EN defined, set night=1 → v1=v2 alternate 1,0,1 on successive ticks with all other lights 0. Clear night → phase=0 and digits 05.
